// File: rtl/spi_pwm_multich.sv
// spi_pwm_multich: N-channel PWM generator configured through a mode-0 SPI slave.
// Period and duty writes are shadowed and only take effect on a wrap or a start event.
module spi_pwm_multich #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            spi_sclk,
  input  logic            spi_mosi,
  input  logic            spi_cs_n,
  output logic            spi_miso,
  input  logic            pwm_start_ext,
  output logic [N_CH-1:0] pwm_out
);
  localparam bit HAS_H = CNT_W > 8;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  logic [2:0] sclk_q, cs_q, ext_q;
  logic [1:0] mosi_q;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, ext_rise, mosi_s;
  state_t state;
  logic [3:0] bit_cnt;
  logic [14:0] sr;
  logic [7:0] tx_sr, rd_data, wr_data;
  logic [6:0] rd_addr, wr_addr;
  logic wr_pend;
  logic [1:0] ctrl;
  logic [N_CH-1:0] ch_en;
  logic [CNT_W-1:0] period, per_sh, cnt;
  logic [CNT_W-1:0] duty [N_CH];
  logic [CNT_W-1:0] duty_sh [N_CH];
  logic run_d, start;
  function automatic logic [CNT_W-1:0] put(logic [CNT_W-1:0] v, logic hi, logic [7:0] d);
    logic [15:0] t;
    t = 16'(v);
    if (hi) t[15:8] = d;
    else t[7:0] = d;
    return t[CNT_W-1:0];
  endfunction
  function automatic logic [7:0] get(logic [CNT_W-1:0] v, logic hi);
    logic [15:0] t;
    t = 16'(v);
    return hi ? t[15:8] : t[7:0];
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '0;
      ext_q  <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      ext_q  <= {ext_q[1:0], pwm_start_ext};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign ext_rise  = ext_q[1] & ~ext_q[2];
  assign mosi_s    = mosi_q[1];
  // At the 8th rise the command byte is the seven shifted bits plus the bit arriving now
  assign rd_addr = {sr[5:0], mosi_s};
  always_comb begin
    rd_data = '0;
    if (rd_addr == 7'h00) rd_data = {6'd0, ctrl};
    if (rd_addr == 7'h01) rd_data = 8'(ch_en);
    if (rd_addr == 7'h02) rd_data = get(period, 1'b0);
    if (rd_addr == 7'h03 && HAS_H) rd_data = get(period, 1'b1);
    for (int c = 0; c < N_CH; c++) begin
      if (rd_addr == 7'(16 + 2*c)) rd_data = get(duty[c], 1'b0);
      if (rd_addr == 7'(17 + 2*c) && HAS_H) rd_data = get(duty[c], 1'b1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      sr       <= '0;
      tx_sr    <= '0;
      spi_miso <= 1'b0;
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_pend <= 1'b0;
      if (cs_rise) begin
        state    <= IDLE;
        spi_miso <= 1'b0;
      end else if (state == IDLE) begin
        if (cs_fall) begin
          state   <= CMD;
          bit_cnt <= '0;
        end
      end else if (state != DONE && sclk_rise) begin
        sr      <= {sr[13:0], mosi_s};
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == 4'd7) begin
          state <= DATA;
          tx_sr <= sr[6] ? 8'h00 : rd_data;
        end
        if (bit_cnt == 4'd15) begin
          state   <= DONE;
          wr_pend <= sr[14];
          wr_addr <= sr[13:7];
          wr_data <= {sr[6:0], mosi_s};
        end
      end else if (state == DATA && sclk_fall) begin
        spi_miso <= tx_sr[7];
        tx_sr    <= {tx_sr[6:0], 1'b0};
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctrl   <= '0;
      ch_en  <= '0;
      period <= '0;
      duty   <= '{default: '0};
    end else if (wr_pend) begin
      if (wr_addr == 7'h00) ctrl <= wr_data[1:0];
      if (wr_addr == 7'h01) ch_en <= wr_data[N_CH-1:0];
      if (wr_addr == 7'h02) period <= put(period, 1'b0, wr_data);
      if (wr_addr == 7'h03 && HAS_H) period <= put(period, 1'b1, wr_data);
      for (int c = 0; c < N_CH; c++) begin
        if (wr_addr == 7'(16 + 2*c)) duty[c] <= put(duty[c], 1'b0, wr_data);
        if (wr_addr == 7'(17 + 2*c) && HAS_H) duty[c] <= put(duty[c], 1'b1, wr_data);
      end
    end
  assign start = ctrl[0] & (~run_d | (ctrl[1] & ext_rise));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_d   <= 1'b0;
      cnt     <= '0;
      per_sh  <= '0;
      duty_sh <= '{default: '0};
      pwm_out <= '0;
    end else begin
      run_d <= ctrl[0];
      if (!ctrl[0]) cnt <= '0;
      else if (start || cnt == per_sh) begin
        cnt     <= '0;
        per_sh  <= period;
        duty_sh <= duty;
      end else cnt <= cnt + 1'b1;
      for (int c = 0; c < N_CH; c++)
        pwm_out[c] <= ctrl[0] & ch_en[c] & (cnt < duty_sh[c]);
    end
endmodule

// File: tb/tb_spi_pwm_multich.sv
// tb_spi_pwm_multich: directed SPI register traffic with hand-computed PWM waveforms.
module tb_spi_pwm_multich;
  localparam int N_CH = 4;
  logic clk = 1'b0, rst_n = 1'b0, spi_sclk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
  logic pwm_start_ext = 1'b0, spi_miso;
  logic [N_CH-1:0] pwm_out;
  int vecs = 0, errs = 0;
  logic mon_en = 1'b0, prev0 = 1'b0, armed = 1'b0;
  int seg = 0, partial = 0, last_seg = -1;
  logic [7:0] rd;
  logic [19:0] cap, exp_cap;
  logic [N_CH-1:0] acc_or, acc_and;
  bit ok;

  spi_pwm_multich #(.N_CH(N_CH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .pwm_start_ext(pwm_start_ext), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  // Counts ch1 high cycles in each ch0 period; any count other than 0 or 5 is a torn period
  always @(negedge clk) begin
    if (!mon_en) begin
      armed = 1'b0;
      seg = 0;
      partial = 0;
    end else begin
      if (pwm_out[0] && !prev0) begin
        if (armed && seg != 0 && seg != 5) partial++;
        if (armed) last_seg = seg;
        seg = 0;
        armed = 1'b1;
      end
      seg += int'(pwm_out[1]);
    end
    prev0 = pwm_out[0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic xfer(input logic [15:0] frame, input int nbits, output logic [7:0] rdata);
    rdata = '0;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = frame[15-i];
      #80;
      if (i >= 8) rdata[15-i] = spi_miso;
      spi_sclk = 1'b1;
      #80;
      spi_sclk = 1'b0;
    end
    #80;
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    xfer({1'b1, a, d}, 16, dummy);
  endtask

  task automatic rd_reg(input logic [6:0] a, output logic [7:0] d);
    xfer({1'b0, a, 8'h00}, 16, d);
  endtask

  task automatic sync0(output bit found);
    logic p;
    found = 1'b0;
    p = pwm_out[0];
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pwm_out[0] && !p) begin
        found = 1'b1;
        break;
      end
      p = pwm_out[0];
    end
  endtask

  task automatic window(input int n);
    acc_or = '0;
    acc_and = '1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      acc_or |= pwm_out;
      acc_and &= pwm_out;
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("reset_pwm", 32'(pwm_out), 32'h0);
    chk("reset_miso", 32'(spi_miso), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    wr(7'h02, 8'h09);
    wr(7'h10, 8'h03);
    wr(7'h01, 8'h01);
    wr(7'h00, 8'h01);
    repeat (20) @(negedge clk);
    sync0(ok);
    chk("sync_basic", 32'(ok), 32'h1);
    cap = '0;
    acc_or = '0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      cap[k] = pwm_out[0];
      exp_cap[k] = (k % 10) < 3;
      acc_or |= pwm_out;
    end
    chk("ch0_wave_p10_d3", 32'(cap), 32'(exp_cap));
    chk("ch123_disabled_low", 32'(acc_or[3:1]), 32'h0);

    wr(7'h01, 8'h03);
    window(25);
    chk("ch1_duty0_low", 32'(acc_or[1]), 32'h0);
    chk("ch0_still_runs", 32'(acc_or[0]), 32'h1);

    mon_en = 1'b1;
    wr(7'h12, 8'h05);
    repeat (35) @(negedge clk);
    chk("ch1_no_torn_period", 32'(partial), 32'h0);
    chk("ch1_high_5", 32'(last_seg), 32'd5);
    mon_en = 1'b0;

    wr(7'h14, 8'h07);
    wr(7'h01, 8'h07);
    wr(7'h00, 8'h03);
    sync0(ok);
    chk("sync_ext", 32'(ok), 32'h1);
    repeat (5) @(negedge clk);
    pwm_start_ext = 1'b1;
    repeat (2) @(negedge clk);
    pwm_start_ext = 1'b0;
    @(negedge clk);
    chk("ext_before_realign", 32'(pwm_out[2:0]), 32'h0);
    @(negedge clk);
    chk("ext_realigned", 32'(pwm_out[2:0]), 32'h7);
    repeat (9) @(negedge clk);
    chk("ext_next_period_low", 32'(pwm_out[2:0]), 32'h0);
    @(negedge clk);
    chk("ext_next_period_rise", 32'(pwm_out[2:0]), 32'h7);

    wr(7'h10, 8'hA5);
    rd_reg(7'h10, rd);
    chk("read_duty0_a5", 32'(rd), 32'hA5);
    rd_reg(7'h7F, rd);
    chk("read_unmapped", 32'(rd), 32'h00);
    rd_reg(7'h02, rd);
    chk("read_period", 32'(rd), 32'h09);
    rd_reg(7'h03, rd);
    chk("read_period_h_absent", 32'(rd), 32'h00);
    rd_reg(7'h00, rd);
    chk("read_ctrl", 32'(rd), 32'h03);
    wr(7'h01, 8'hFF);
    rd_reg(7'h01, rd);
    chk("read_chen_masked", 32'(rd), 32'h0F);

    window(25);
    chk("ch0_duty_gt_period_high", 32'(acc_and[0]), 32'h1);
    chk("ch3_duty0_low", 32'(acc_or[3]), 32'h0);

    xfer({1'b1, 7'h10, 8'h33}, 10, rd);
    rd_reg(7'h10, rd);
    chk("abort_no_commit", 32'(rd), 32'hA5);

    wr(7'h01, 8'h00);
    window(25);
    chk("chen0_all_low", 32'(acc_or), 32'h0);

    wr(7'h01, 8'h01);
    repeat (3) @(negedge clk);
    chk("pre_reset_high", 32'(pwm_out[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_pwm", 32'(pwm_out), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd_reg(7'h10, rd);
    chk("reset_duty0_clear", 32'(rd), 32'h00);
    rd_reg(7'h00, rd);
    chk("reset_ctrl_clear", 32'(rd), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
